// File: rtl/dmem_arbiter_if.sv
// Requester and Memoria64 signal bundle for dmem_arbiter.
// slave = arbiter view, master = environment (requesters + memory) view.
interface dmem_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          REQ0;
    logic          WE0;
    logic [AW-1:0] ADDR0;
    logic [DW-1:0] WDATA0;
    logic          GNT0;
    logic          ACK0;
    logic [DW-1:0] RDATA0;

    logic          REQ1;
    logic          WE1;
    logic [AW-1:0] ADDR1;
    logic [DW-1:0] WDATA1;
    logic          GNT1;
    logic          ACK1;
    logic [DW-1:0] RDATA1;

    logic [AW-1:0] MEM_RADDR;
    logic [AW-1:0] MEM_WADDR;
    logic [DW-1:0] MEM_DATAIN;
    logic          MEM_WR;
    logic [DW-1:0] MEM_DATAOUT;
    logic          BUSY;

    modport slave (
        input  REQ0, WE0, ADDR0, WDATA0,
        input  REQ1, WE1, ADDR1, WDATA1,
        input  MEM_DATAOUT,
        output GNT0, ACK0, RDATA0,
        output GNT1, ACK1, RDATA1,
        output MEM_RADDR, MEM_WADDR, MEM_DATAIN, MEM_WR, BUSY
    );

    modport master (
        output REQ0, WE0, ADDR0, WDATA0,
        output REQ1, WE1, ADDR1, WDATA1,
        output MEM_DATAOUT,
        input  GNT0, ACK0, RDATA0,
        input  GNT1, ACK1, RDATA1,
        input  MEM_RADDR, MEM_WADDR, MEM_DATAIN, MEM_WR, BUSY
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Memoria64 arbiter, CPU (port 0) vs loader (port 1); round-robin ties, or CPU priority with DMEM_ARB_CPU_PRIORITY_EN.
// Latency: GNT 1 cycle after REQ sampled in IDLE; ACK at +2 (write) or +READ_LAT+1 (read); all outputs registered.
// Backpressure: REQ sampled only in IDLE; requester holds REQ/WE/ADDR/WDATA until it sees its GNT.
module dmem_arbiter #(
    parameter int AW       = 64,
    parameter int DW       = 64,
    parameter int READ_LAT = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last;
    logic       sel;
    logic       we_q;
    logic [2:0] lat_cnt;
    logic       win;
    logic       grant;
    logic       access_done;
    logic       gnt0_d;
    logic       gnt1_d;
    logic       ack0_d;
    logic       ack1_d;
    logic       wr_d;
    logic       busy_d;

    // A lone requester always wins; on a tie the port that was not served last wins.
    always_comb begin
        win = 1'b0;
        if (bus.REQ0 && bus.REQ1) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
            win = 1'b0;
`else
            win = ~last;
`endif
        end else begin
            win = bus.REQ1;
        end
    end

    assign grant       = (state == IDLE) && (bus.REQ0 || bus.REQ1);
    assign access_done = (state == ACCESS) && (we_q || (lat_cnt == LAT_LAST));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant)       state_nxt = ACCESS;
            ACCESS:  if (access_done) state_nxt = RESP;
            RESP:                     state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0_d = grant && !win;
        gnt1_d = grant && win;
        wr_d   = grant && (win ? bus.WE1 : bus.WE0);
        ack0_d = access_done && !sel;
        ack1_d = access_done && sel;
        busy_d = (state_nxt != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.GNT0   <= 1'b0;
            bus.GNT1   <= 1'b0;
            bus.ACK0   <= 1'b0;
            bus.ACK1   <= 1'b0;
            bus.MEM_WR <= 1'b0;
            bus.BUSY   <= 1'b0;
        end else begin
            bus.GNT0   <= gnt0_d;
            bus.GNT1   <= gnt1_d;
            bus.ACK0   <= ack0_d;
            bus.ACK1   <= ack1_d;
            bus.MEM_WR <= wr_d;
            bus.BUSY   <= busy_d;
        end
    end

    // Address/data hold their last latched value while idle; RDATAx holds until that port's next read.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last           <= 1'b1;
            sel            <= 1'b0;
            we_q           <= 1'b0;
            lat_cnt        <= 3'd0;
            bus.MEM_RADDR  <= '0;
            bus.MEM_WADDR  <= '0;
            bus.MEM_DATAIN <= '0;
            bus.RDATA0     <= '0;
            bus.RDATA1     <= '0;
        end else begin
            if (grant) begin
                last           <= win;
                sel            <= win;
                we_q           <= win ? bus.WE1 : bus.WE0;
                lat_cnt        <= 3'd0;
                bus.MEM_RADDR  <= win ? bus.ADDR1 : bus.ADDR0;
                bus.MEM_WADDR  <= win ? bus.ADDR1 : bus.ADDR0;
                bus.MEM_DATAIN <= win ? bus.WDATA1 : bus.WDATA0;
            end else if (state == ACCESS) begin
                lat_cnt <= lat_cnt + 3'd1;
            end
            if (access_done && !we_q) begin
                if (sel) begin
                    bus.RDATA1 <= bus.MEM_DATAOUT;
                end else begin
                    bus.RDATA0 <= bus.MEM_DATAOUT;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: one arbiter with READ_LAT=1 (ia) and one with READ_LAT=3 (ib) driven by the same requesters.
// Both share a small memory; ib sees Dataout through a 2-stage pipe so early capture reads stale data.
module tb_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [63:0] addr0, wdata0, addr1, wdata1;
    logic [63:0] mem [0:255];
    logic        mem_load;
    logic [63:0] p1, p2;
    logic [3:0]  exp_seq;
    int          n_tests;
    int          n_fail;
    int          ng;
    logic        got1;
    logic        drained;

    dmem_arbiter_if #(.AW(64), .DW(64)) ia ();
    dmem_arbiter_if #(.AW(64), .DW(64)) ib ();

    dmem_arbiter #(.AW(64), .DW(64), .READ_LAT(1)) u_lat1 (.CLK(clk), .RESET(rst), .bus(ia.slave));
    dmem_arbiter #(.AW(64), .DW(64), .READ_LAT(3)) u_lat3 (.CLK(clk), .RESET(rst), .bus(ib.slave));

    assign ia.REQ0 = req0;  assign ia.WE0 = we0;  assign ia.ADDR0 = addr0;  assign ia.WDATA0 = wdata0;
    assign ia.REQ1 = req1;  assign ia.WE1 = we1;  assign ia.ADDR1 = addr1;  assign ia.WDATA1 = wdata1;
    assign ib.REQ0 = req0;  assign ib.WE0 = we0;  assign ib.ADDR0 = addr0;  assign ib.WDATA0 = wdata0;
    assign ib.REQ1 = req1;  assign ib.WE1 = we1;  assign ib.ADDR1 = addr1;  assign ib.WDATA1 = wdata1;

    assign ia.MEM_DATAOUT = mem[ia.MEM_RADDR[7:0]];
    assign ib.MEM_DATAOUT = p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'h0;
            mem[8'h10] <= 64'hDEADBEEF;
        end else if (ia.MEM_WR) begin
            mem[ia.MEM_WADDR[7:0]] <= ia.MEM_DATAIN;
        end
        p1 <= mem[ib.MEM_RADDR[7:0]];
        p2 <= p1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
`ifdef DMEM_ARB_CPU_PRIORITY_EN
        exp_seq = 4'b0000;
`else
        exp_seq = 4'b1010;
`endif
        mem_load = 1'b1;
        rst  = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 64'h0; wdata0 = 64'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 64'h0; wdata1 = 64'h0;

        // Reset held 3 cycles.
        repeat (3) tick();
        check("rst_gnt0",   ia.GNT0, 0);
        check("rst_gnt1",   ia.GNT1, 0);
        check("rst_ack0",   ia.ACK0, 0);
        check("rst_ack1",   ia.ACK1, 0);
        check("rst_busy",   ia.BUSY, 0);
        check("rst_wr",     ia.MEM_WR, 0);
        check("rst_rdata0", ia.RDATA0, 0);
        check("rst_raddr",  ia.MEM_RADDR, 0);
        check("rst_busy3",  ib.BUSY, 0);
        rst = 1'b0;
        mem_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("idle_wr",   ia.MEM_WR | ib.MEM_WR, 0);
            check("idle_busy", ia.BUSY | ib.BUSY, 0);
        end

        // Port 0 read of 0x10 on both latencies.
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("rd_gnt0",   ia.GNT0, k == 1);
            check("rd_ack0",   ia.ACK0, k == 2);
            check("rd_busy",   ia.BUSY, (k == 1) || (k == 2));
            check("rd_wr",     ia.MEM_WR, 0);
            check("rd3_gnt0",  ib.GNT0, k == 1);
            check("rd3_ack0",  ib.ACK0, k == 4);
            check("rd3_busy",  ib.BUSY, (k >= 1) && (k <= 4));
            if (k == 1) begin
                check("rd_raddr",  ia.MEM_RADDR, 64'h10);
                check("rd3_raddr", ib.MEM_RADDR, 64'h10);
                req0 = 1'b0;
            end
            if (k == 2) check("rd_rdata0",  ia.RDATA0, 64'hDEADBEEF);
            if (k == 3) check("rd3_early",  ib.RDATA0, 64'h0);
            if (k == 4) check("rd3_rdata0", ib.RDATA0, 64'hDEADBEEF);
        end

        // Port 1 write of 0x55 to 0x20.
        req1 = 1'b1; we1 = 1'b1; addr1 = 64'h20; wdata1 = 64'h55;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("wr_gnt1",   ia.GNT1, k == 1);
            check("wr_memwr",  ia.MEM_WR, k == 1);
            check("wr_ack1",   ia.ACK1, k == 2);
            check("wr_rdata1", ia.RDATA1, 64'h0);
            check("wr3_ack1",  ib.ACK1, k == 2);
            if (k == 1) begin
                check("wr_waddr", ia.MEM_WADDR, 64'h20);
                check("wr_din",   ia.MEM_DATAIN, 64'h55);
                req1 = 1'b0;
            end
        end
        tick();

        // Both ports reading continuously.
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h20;
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            tick();
            check("rr_onehot", ia.GNT0 & ia.GNT1, 0);
            if (ia.ACK0) check("rr_rdata0", ia.RDATA0, 64'hDEADBEEF);
            if (ia.ACK1) check("rr_rdata1", ia.RDATA1, 64'h55);
            if (ia.GNT0 | ia.GNT1) begin
                check("rr_order", ia.GNT1, exp_seq[ng]);
                ng++;
            end
        end
        check("rr_count", ng, 4);
        req0 = 1'b0;
        got1 = 1'b0;
        for (int c = 0; c < 10 && !got1; c++) begin
            tick();
            if (ia.GNT0 | ia.GNT1) begin
                check("solo_gnt1", ia.GNT1, 1);
                got1 = 1'b1;
            end
        end
        check("solo_seen", got1, 1);
        req1 = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            tick();
            if (!ia.BUSY && !ib.BUSY && !ia.GNT0 && !ia.GNT1 && !ib.GNT0 && !ib.GNT1) drained = 1'b1;
        end
        check("drain", drained, 1);
        repeat (2) tick();

        // READ_LAT=3 read interrupted by reset.
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
        tick();
        check("mid_gnt0", ib.GNT0, 1);
        req0 = 1'b0;
        tick();
        check("mid_busy", ib.BUSY, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_gnt0_0", ib.GNT0, 0);
        check("mid_ack0",   ib.ACK0, 0);
        check("mid_busy_0", ib.BUSY, 0);
        check("mid_wr",     ib.MEM_WR, 0);
        check("mid_rdata0", ib.RDATA0, 0);
        check("mid_raddr",  ib.MEM_RADDR, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_noack", ib.ACK0, 0);
        end
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h20;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                check("post_gnt1", ib.GNT1, 1);
                req1 = 1'b0;
            end
            check("post_ack1", ib.ACK1, k == 4);
            if (k == 4) check("post_rdata1", ib.RDATA1, 64'h55);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
